// File: rtl/mpu_core.sv
// mpu_core: fixed-map memory protection unit for a Harvard CPU.
// Checks each fetch/load/store address against the code, MMIO and data regions
// and the current privilege level. Gives a same-cycle allow and registered
// per-type fault pulses.
// Ports: clk, rst (sync, active-high); addr, is_fetch, is_load, is_store, cur_priv in;
//        allow (combinational), fault_exec, fault_load, fault_store (registered) out.
// Optional MPU_FAULT_LATCH_EN: fault_clr in; fault_addr, fault_cause out
//        (first fault after reset/clear, cause 01 exec, 10 load, 11 store).
module mpu_core #(
    parameter logic [31:0] CODE_BASE = 32'h0000_0000,
    parameter logic [31:0] CODE_SIZE = 32'h1000_0000,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter logic [31:0] MMIO_SIZE = 32'h1000_0000,
    parameter logic [31:0] DATA_BASE = 32'h2000_0000,
    parameter logic [31:0] DATA_SIZE = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        is_fetch,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [1:0]  cur_priv,
`ifdef MPU_FAULT_LATCH_EN
    input  logic        fault_clr,
    output logic [31:0] fault_addr,
    output logic [1:0]  fault_cause,
`endif
    output logic        allow,
    output logic        fault_exec,
    output logic        fault_load,
    output logic        fault_store
);
    // 33-bit compare so base+size-1 never wraps
    function automatic logic in_region(input logic [31:0] a, input logic [31:0] base,
                                       input logic [31:0] size);
        return ({1'b0, a} >= {1'b0, base}) &&
               ({1'b0, a} <= {1'b0, base} + {1'b0, size} - 33'd1);
    endfunction

    logic in_code, in_mmio, in_data, priv_ok, perm_data, deny_f, deny_l, deny_s;

    always_comb begin
        in_code   = in_region(addr, CODE_BASE, CODE_SIZE);
        in_mmio   = in_region(addr, MMIO_BASE, MMIO_SIZE);
        in_data   = in_region(addr, DATA_BASE, DATA_SIZE);
        // S (01) and M (11) are privileged; U (00) and the reserved 10 are not
        priv_ok   = cur_priv[0];
        perm_data = in_data | (in_mmio & priv_ok);
        deny_f    = is_fetch & ~in_code;
        deny_l    = is_load & ~perm_data;
        deny_s    = is_store & ~perm_data;
        allow     = ~(deny_f | deny_l | deny_s);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_exec  <= 1'b0;
            fault_load  <= 1'b0;
            fault_store <= 1'b0;
        end else begin
            fault_exec  <= deny_f;
            fault_load  <= deny_l;
            fault_store <= deny_s;
        end
    end

`ifdef MPU_FAULT_LATCH_EN
    // A zero cause means the latch is empty; a clear re-opens it, and a fault
    // arriving with the clear is captured immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_addr  <= 32'd0;
            fault_cause <= 2'b00;
        end else if (fault_clr || fault_cause == 2'b00) begin
            fault_addr  <= (deny_f | deny_l | deny_s) ? addr : 32'd0;
            fault_cause <= deny_s ? 2'b11 : deny_l ? 2'b10 : deny_f ? 2'b01 : 2'b00;
        end
    end
`endif
endmodule

// File: tb/tb_mpu_core.sv
// tb_mpu_core: scoreboard bench for mpu_core with directed vectors.
module tb_mpu_core;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        is_fetch, is_load, is_store;
    logic [1:0]  cur_priv;
    logic        allow, fault_exec, fault_load, fault_store;
    logic        fault_clr;
`ifdef MPU_FAULT_LATCH_EN
    logic [31:0] fault_addr;
    logic [1:0]  fault_cause;
`endif

    int checks = 0;
    int fails  = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    mpu_core dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .is_fetch(is_fetch),
        .is_load(is_load),
        .is_store(is_store),
        .cur_priv(cur_priv),
`ifdef MPU_FAULT_LATCH_EN
        .fault_clr(fault_clr),
        .fault_addr(fault_addr),
        .fault_cause(fault_cause),
`endif
        .allow(allow),
        .fault_exec(fault_exec),
        .fault_load(fault_load),
        .fault_store(fault_store)
    );

    typedef struct {
        logic        r;
        logic [31:0] a;
        logic [2:0]  fls;
        logic [1:0]  p;
        logic        ex_allow;
        logic [2:0]  ex_fault;
    } vec_t;

    // fls = {fetch, load, store}; ex_fault = {exec, load, store} one cycle later
    vec_t vecs[] = '{
        '{1'b1, 32'h1000_0000, 3'b001, 2'b00, 1'b0, 3'b000},
        '{1'b1, 32'h0000_0000, 3'b000, 2'b00, 1'b1, 3'b000},
        '{1'b1, 32'h0000_0000, 3'b000, 2'b00, 1'b1, 3'b000},
        '{1'b0, 32'h0000_0000, 3'b000, 2'b00, 1'b1, 3'b000},
        '{1'b0, 32'h1000_0000, 3'b001, 2'b00, 1'b0, 3'b001},
        '{1'b0, 32'h1000_0000, 3'b000, 2'b00, 1'b1, 3'b000},
        '{1'b0, 32'h1000_0004, 3'b011, 2'b11, 1'b1, 3'b000},
        '{1'b0, 32'h1000_0004, 3'b010, 2'b00, 1'b0, 3'b010},
        '{1'b0, 32'h0000_0100, 3'b100, 2'b00, 1'b1, 3'b000},
        '{1'b0, 32'h2000_0000, 3'b100, 2'b00, 1'b0, 3'b100},
        '{1'b0, 32'h0000_0100, 3'b001, 2'b00, 1'b0, 3'b001},
        '{1'b0, 32'h3000_0000, 3'b010, 2'b01, 1'b0, 3'b010},
        '{1'b0, 32'h3000_0000, 3'b010, 2'b11, 1'b0, 3'b010},
        '{1'b0, 32'h2FFF_FFFC, 3'b010, 2'b00, 1'b1, 3'b000},
        '{1'b0, 32'h3000_0000, 3'b111, 2'b11, 1'b0, 3'b111},
        '{1'b0, 32'h1000_0000, 3'b110, 2'b01, 1'b0, 3'b100},
        '{1'b0, 32'h0FFF_FFFC, 3'b100, 2'b00, 1'b1, 3'b000},
        '{1'b0, 32'h1000_0000, 3'b100, 2'b11, 1'b0, 3'b100},
        '{1'b0, 32'h1000_0000, 3'b010, 2'b10, 1'b0, 3'b010},
        '{1'b0, 32'h1FFF_FFFF, 3'b001, 2'b01, 1'b1, 3'b000},
        '{1'b0, 32'h1FFF_FFFF, 3'b010, 2'b00, 1'b0, 3'b010},
        '{1'b0, 32'h0000_0000, 3'b110, 2'b00, 1'b0, 3'b010},
        '{1'b0, 32'hFFFF_FFFF, 3'b001, 2'b11, 1'b0, 3'b001},
        '{1'b0, 32'h0000_0000, 3'b000, 2'b00, 1'b1, 3'b000}
    };

    task automatic step(input vec_t v);
        @(negedge clk);
        rst = v.r;
        addr = v.a;
        {is_fetch, is_load, is_store} = v.fls;
        cur_priv = v.p;
        #1;
        checks++;
        if (allow !== v.ex_allow) begin
            fails++;
            $display("FAIL allow addr=%h fls=%b priv=%b got=%b want=%b",
                     v.a, v.fls, v.p, allow, v.ex_allow);
        end
        exp_q.push_back(v.ex_fault);
    endtask

`ifdef MPU_FAULT_LATCH_EN
    task automatic chk_latch(input string name, input logic [31:0] ea, input logic [1:0] ec);
        @(negedge clk);
        checks++;
        if (fault_addr !== ea || fault_cause !== ec) begin
            fails++;
            $display("FAIL %s fault_addr=%h cause=%b want %h/%b",
                     name, fault_addr, fault_cause, ea, ec);
        end
    endtask
`endif

    // monitor: compares registered faults once per cycle against the scoreboard
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [2:0] e;
                e = exp_q.pop_front();
                checks++;
                if ({fault_exec, fault_load, fault_store} !== e) begin
                    fails++;
                    $display("FAIL faults got=%b want=%b",
                             {fault_exec, fault_load, fault_store}, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        addr = 32'd0;
        {is_fetch, is_load, is_store} = 3'b000;
        cur_priv = 2'b00;
        fault_clr = 1'b0;
        foreach (vecs[i]) step(vecs[i]);
`ifdef MPU_FAULT_LATCH_EN
        fault_clr = 1'b1;
        step('{1'b0, 32'h0, 3'b000, 2'b00, 1'b1, 3'b000});
        fault_clr = 1'b0;
        step('{1'b0, 32'h1000_0010, 3'b001, 2'b00, 1'b0, 3'b001});
        step('{1'b0, 32'h3000_0000, 3'b010, 2'b00, 1'b0, 3'b010});
        step('{1'b0, 32'h0, 3'b000, 2'b00, 1'b1, 3'b000});
        chk_latch("latch_first", 32'h1000_0010, 2'b11);
        fault_clr = 1'b1;
        step('{1'b0, 32'h0, 3'b000, 2'b00, 1'b1, 3'b000});
        fault_clr = 1'b0;
        chk_latch("latch_clear", 32'h0, 2'b00);
        fault_clr = 1'b1;
        step('{1'b0, 32'h3000_0000, 3'b010, 2'b00, 1'b0, 3'b010});
        fault_clr = 1'b0;
        step('{1'b0, 32'h0, 3'b000, 2'b00, 1'b1, 3'b000});
        chk_latch("latch_clr_new", 32'h3000_0000, 2'b10);
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
